dmem_responder: RTL and testbench

- Data-memory responder that sits on the far side of the CPU load/store port.
- Accepts one load or store request at a time from the core over a valid/ready handshake, inserts a fixed number of wait states, and returns a response over a second valid/ready handshake.
- Size and sign handling (byte/half/word, signed/unsigned) happens inside this block, so the core sees final 32-bit register-ready load data.
- Backing store is an internal little-endian word array.

---
 rtl/dmem_responder.sv | 185 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port: one request at a time,
// fixed wait states, byte/half/word access with sign handling, little-endian word array.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [33:0] LIMIT    = 34'(DEPTH) * 34'd4;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        ready_nxt;
  logic        valid_nxt;
  logic        err_nxt;
  logic [31:0] rdata_nxt;
  logic        accept;
  logic        commit;
  logic        mem_we;

  logic [3:0]  mode_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0] word_rd;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        bad;

  function automatic logic access_err(input logic [3:0] m, input logic [31:0] a);
    logic e;
    e = 1'b0;
    case (m[1:0])
      2'b01:   e = a[0];
      2'b10:   e = |a[1:0];
      2'b11:   e = 1'b1;
      default: e = 1'b0;
    endcase
    if ({2'b00, a} >= LIMIT) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0] m, input logic [1:0] lo,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (m[1:0])
      2'b00:   r = m[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = m[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Byte enables and lane-replicated data so each lane sees its own store byte.
  function automatic logic [3:0] store_be(input logic [3:0] m, input logic [1:0] lo);
    logic [3:0] be;
    case (m[1:0])
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] m, input logic [31:0] d);
    logic [31:0] r;
    case (m[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  assign idx     = addr_q[AW+1:2];
  assign word_rd = mem[idx];
  assign bad     = access_err(mode_q, addr_q);
  assign wr_be   = store_be(mode_q, addr_q[1:0]);
  assign wr_data = store_data(mode_q, wdata_q);
  assign mem_we  = commit && mode_q[3] && !bad;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = req_ready;
    valid_nxt = resp_valid;
    rdata_nxt = resp_rdata;
    err_nxt   = resp_err;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          ready_nxt = 1'b0;
          cnt_nxt   = CNT_INIT;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
          valid_nxt = 1'b1;
          err_nxt   = bad;
          rdata_nxt = (bad || mode_q[3]) ? 32'd0 : load_extend(mode_q, addr_q[1:0], word_rd);
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          valid_nxt = 1'b0;
          err_nxt   = 1'b0;
          rdata_nxt = 32'd0;
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= ready_nxt;
      resp_valid <= valid_nxt;
      resp_rdata <= rdata_nxt;
      resp_err   <= err_nxt;
    end
  end

  // Request fields are plain data; they only matter once the FSM has accepted them.
  always_ff @(posedge clk) begin
    if (accept) begin
      mode_q  <= req_mode;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of load/store transactions plus
// hand-written backpressure, early-ready and reset-abort sequences.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_mode = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  localparam logic [3:0] SW = 4'b1010, LW = 4'b0010, LWU = 4'b0110;
  localparam logic [3:0] SB = 4'b1000, LB = 4'b0000, LBU = 4'b0100;
  localparam logic [3:0] SH = 4'b1001, LH = 4'b0001, LHU = 4'b0101;
  localparam logic [3:0] L11 = 4'b0011, S11 = 4'b1011;

  typedef struct {
    string       name;
    logic [3:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic add(input string n, input logic [3:0] m, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input logic er);
    vec_t v;
    v.name = n; v.mode = m; v.addr = a; v.wdata = wd; v.exp_rd = rd; v.exp_err = er;
    vecs.push_back(v);
  endtask

  // Drive a request and return just after its accept edge; ok=0 if never accepted.
  task automatic issue(input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd,
                       output bit ok);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_mode = m; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (ok) begin
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic txn(input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    bit ok;
    issue(m, a, wd, ok);
    lat = -1;
    rd  = 32'hxxxxxxxx;
    er  = 1'bx;
    if (ok) begin
      lat = 0;
      while (!resp_valid && lat < 50) begin
        @(posedge clk);
        #1;
        lat++;
      end
      rd = resp_rdata;
      er = resp_err;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          ok;

    add("sw_10",      SW,  32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
    add("lw_10",      LW,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    add("sb_13",      SB,  32'h13,  32'h00000080, 32'h0,        1'b0);
    add("lb_13",      LB,  32'h13,  32'h0,        32'hFFFFFF80, 1'b0);
    add("lbu_13",     LBU, 32'h13,  32'h0,        32'h00000080, 1'b0);
    add("lw_10_b",    LW,  32'h10,  32'h0,        32'h80ADBEEF, 1'b0);
    add("lb_10",      LB,  32'h10,  32'h0,        32'hFFFFFFEF, 1'b0);
    add("lh_21_err",  LH,  32'h21,  32'h0,        32'h0,        1'b1);
    add("sw_12_err",  SW,  32'h12,  32'h12345678, 32'h0,        1'b1);
    add("lw_10_c",    LW,  32'h10,  32'h0,        32'h80ADBEEF, 1'b0);
    add("lw_400_err", LW,  32'h400, 32'h0,        32'h0,        1'b1);
    add("l11_err",    L11, 32'h10,  32'h0,        32'h0,        1'b1);
    add("s11_err",    S11, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1);
    add("lw_10_d",    LW,  32'h10,  32'h0,        32'h80ADBEEF, 1'b0);
    add("sw_3fc",     SW,  32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0);
    add("lw_3fc",     LW,  32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0);
    add("sb_400_err", SB,  32'h400, 32'h000000AA, 32'h0,        1'b1);
    add("sw_20",      SW,  32'h20,  32'h55667788, 32'h0,        1'b0);
    add("sh_22",      SH,  32'h22,  32'hFFFF8001, 32'h0,        1'b0);
    add("lh_22",      LH,  32'h22,  32'h0,        32'hFFFF8001, 1'b0);
    add("lhu_22",     LHU, 32'h22,  32'h0,        32'h00008001, 1'b0);
    add("lh_20",      LH,  32'h20,  32'h0,        32'h00007788, 1'b0);
    add("lb_21",      LB,  32'h21,  32'h0,        32'h00000077, 1'b0);
    add("lbu_23",     LBU, 32'h23,  32'h0,        32'h00000080, 1'b0);
    add("sh_21_err",  SH,  32'h21,  32'h0000BEEF, 32'h0,        1'b1);
    add("lwu_20",     LWU, 32'h20,  32'h0,        32'h80017788, 1'b0);
    add("sw_40",      SW,  32'h40,  32'h11111111, 32'h0,        1'b0);
    add("lw_40",      LW,  32'h40,  32'h0,        32'h11111111, 1'b0);

    // Reset held three cycles, ready one edge after release
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    end
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_ready_high", {31'd0, req_ready}, 32'd1);

    foreach (vecs[i]) begin
      txn(vecs[i].mode, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_err"}, {31'd0, er}, {31'd0, vecs[i].exp_err});
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(LAT));
    end

    // Backpressure: response held, competing request ignored
    issue(LW, 32'h10, 32'h0, ok);
    chk("bp_accept", {31'd0, ok}, 32'd1);
    repeat (LAT) begin
      @(posedge clk);
      #1;
    end
    chk("bp_valid_rise", {31'd0, resp_valid}, 32'd1);
    req_valid = 1'b1; req_mode = SW; req_addr = 32'h10; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid_hold", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata_hold", resp_rdata, 32'h80ADBEEF);
      chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("bp_valid_drop", {31'd0, resp_valid}, 32'd0);
    chk("bp_rdata_clear", resp_rdata, 32'd0);
    chk("bp_ready_back", {31'd0, req_ready}, 32'd1);
    txn(LW, 32'h10, 32'h0, rd, er, lat);
    chk("bp_ignored_store", rd, 32'h80ADBEEF);

    // resp_ready already high: response lives exactly one cycle
    resp_ready = 1'b1;
    issue(LW, 32'h40, 32'h0, ok);
    chk("early_accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    chk("early_not_yet", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("early_valid", {31'd0, resp_valid}, 32'd1);
    chk("early_rdata", resp_rdata, 32'h11111111);
    @(posedge clk);
    #1;
    chk("early_consumed", {31'd0, resp_valid}, 32'd0);
    chk("early_ready_back", {31'd0, req_ready}, 32'd1);
    resp_ready = 1'b0;

    // Reset while a response is pending clears outputs asynchronously
    issue(LW, 32'h10, 32'h0, ok);
    repeat (LAT) begin
      @(posedge clk);
      #1;
    end
    chk("rresp_valid_pre", {31'd0, resp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rresp_valid_clr", {31'd0, resp_valid}, 32'd0);
    chk("rresp_rdata_clr", resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during WAIT of a store: the store never commits
    issue(SW, 32'h40, 32'h22222222, ok);
    chk("rwait_accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rwait_ready", {31'd0, req_ready}, 32'd0);
    chk("rwait_valid", {31'd0, resp_valid}, 32'd0);
    chk("rwait_err", {31'd0, resp_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    txn(LW, 32'h40, 32'h0, rd, er, lat);
    chk("rwait_no_write", rd, 32'h11111111);
    chk("rwait_no_err", {31'd0, er}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
